// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_pkg
// Description : Shared types and constants for the data memory responder:
//               FSM state encoding, default geometry/latency, field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int DEFAULT_LATENCY     = 2;

    // Request / response field widths
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int WIDX_W = ADDR_W - 2;   // word index = addr[31:2]
    localparam int CNT_W  = 4;            // holds LATENCY-1 for LATENCY 1..15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
// Module      : word_ram
// Description : Word-wide storage array with synchronous byte-enable write
//               and synchronous registered read. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module word_ram
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register only updates on a read, so the last load value is held
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_responder
// Description : Single-outstanding load/store responder. A request accepted
//               in IDLE waits LATENCY edges, then commits/reads the word RAM
//               and presents a registered response until it is taken.
//               LATENCY legal range is 1..15.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int c_ram_aw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_live;        // low from reset assertion until first edge after release
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic [WIDX_W-1:0]   r_widx;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_rsp_err;
    logic                r_rsp_load;    // response carries RAM read data
    logic                w_accept;
    logic                w_finish;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic                w_unused;

    // Byte offset bits are don't-care for word accesses
    assign w_unused   = &{1'b0, req_addr[1:0]};

    assign w_accept   = (r_state == ST_IDLE) && req_valid && r_live;
    assign w_finish   = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_in_range = r_widx < WIDX_W'(DEPTH_WORDS);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = r_live;
                if (w_accept) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Hold req_ready low while reset is asserted; open up on the first edge after
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Capture the request at acceptance and run the latency down-counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_widx  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_write <= req_write;
            r_widx  <= req_addr[ADDR_W-1:2];
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Response status registered on the WAIT->RESP edge, held until next request completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_err  <= 1'b0;
            r_rsp_load <= 1'b0;
        end else if (w_finish) begin
            r_rsp_err  <= !w_in_range;
            r_rsp_load <= !r_write && w_in_range;
        end
    end

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_word_ram (
        .clk     (clk),
        .i_we    (w_finish && r_write && w_in_range),
        .i_re    (w_finish && !r_write && w_in_range),
        .i_addr  (r_widx[c_ram_aw-1:0]),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register only changes on a load, so gating it gives a held value
    assign rsp_rdata = r_rsp_load ? w_ram_rdata : '0;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
